// File: rtl/seq_search_cam.sv
// rtl/seq_search_cam.sv - writable CAM with a one-entry-per-clock sequential search engine
// Optional CAM_MATCH_COUNT_EN: full-table scan with a match_count output.
module seq_search_cam #(
    parameter int DATA_W = 5,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    input  logic              search_start,
    input  logic [DATA_W-1:0] search_key,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] match_addr
`ifdef CAM_MATCH_COUNT_EN
    ,
    output logic [ADDR_W:0]   match_count
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    valid_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [DATA_W-1:0]   key_q;
    logic                start_ok;
    logic                hit;
    logic                last;

    // Data words carry no reset; only the valid bits gate a match.
    always_ff @(posedge clk) begin
        if (wr_en && wr_valid) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        hit      = valid_q[ptr_q] && (mem[ptr_q] == key_q);
        last     = (ptr_q == LAST);
        case (state_q)
            IDLE, DONE: begin
                if (search_start) begin
                    start_ok = 1'b1;
                    state_d  = SCAN;
                end else begin
                    state_d  = IDLE;
                end
            end
            SCAN: begin
`ifdef CAM_MATCH_COUNT_EN
                if (last) begin
                    state_d = DONE;
                end
`else
                if (hit || last) begin
                    state_d = DONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Compare reads pre-edge contents, so a write to the entry under compare is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            ptr_q       <= '0;
            key_q       <= '0;
            found       <= 1'b0;
            match_addr  <= '0;
`ifdef CAM_MATCH_COUNT_EN
            match_count <= '0;
`endif
        end else begin
            if (wr_en) begin
                valid_q[wr_addr] <= wr_valid;
            end
            if (start_ok) begin
                key_q       <= search_key;
                ptr_q       <= '0;
                found       <= 1'b0;
                match_addr  <= '0;
`ifdef CAM_MATCH_COUNT_EN
                match_count <= '0;
`endif
            end else if (state_q == SCAN) begin
                if (!last) begin
                    ptr_q <= ptr_q + 1'b1;
                end
                if (hit && !found) begin
                    found      <= 1'b1;
                    match_addr <= ptr_q;
                end
`ifdef CAM_MATCH_COUNT_EN
                if (hit) begin
                    match_count <= match_count + 1'b1;
                end
`endif
            end
        end
    end

    assign busy = (state_q == SCAN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_search_cam.sv
// tb/tb_seq_search_cam.sv - self-checking bench for seq_search_cam
// Honours CAM_MATCH_COUNT_EN when the design is built with it.
module tb_seq_search_cam;

    localparam int DATA_W = 5;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
`ifdef CAM_MATCH_COUNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_valid = 1'b0;
    logic              search_start = 1'b0;
    logic [DATA_W-1:0] search_key = '0;
    logic              busy;
    logic              done;
    logic              found;
    logic [ADDR_W-1:0] match_addr;
`ifdef CAM_MATCH_COUNT_EN
    logic [ADDR_W:0]   match_count;
`endif

    seq_search_cam #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_valid(wr_valid), .search_start(search_start), .search_key(search_key),
        .busy(busy), .done(done), .found(found), .match_addr(match_addr)
`ifdef CAM_MATCH_COUNT_EN
        , .match_count(match_count)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Model: write log with cycle stamps plus the last accepted search.
    int          lq_c[$];
    int          lq_a[$];
    bit          lq_v[$];
    logic [4:0]  lq_d[$];
    bit          has_s = 1'b0;
    int          s_cyc = 0;
    logic [4:0]  s_key = '0;
    bit          m_busy = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    task automatic model_reset();
        lq_c.delete(); lq_a.delete(); lq_v.delete(); lq_d.delete();
        has_s  = 1'b0;
        m_busy = 1'b0;
    endtask

    // Entry contents as left by all writes issued up to and including cycle upto.
    function automatic bit hit_at(input int addr, input int upto, input logic [4:0] key);
        for (int j = lq_c.size() - 1; j >= 0; j--)
            if (lq_a[j] == addr && lq_c[j] <= upto) return lq_v[j] && (lq_d[j] == key);
        return 1'b0;
    endfunction

    // Entry i is compared in cycle s+1+i; dc = done cycle, -1 while not yet determined.
    function automatic void plan(input int t, output int dc, output bit f, output int a, output int n);
        int last_i;
        dc = -1; f = 1'b0; a = 0; n = 0;
        last_i = t - 2 - s_cyc;
        if (last_i > DEPTH - 1) last_i = DEPTH - 1;
        for (int i = 0; i <= last_i; i++) begin
            if (hit_at(i, s_cyc + i, s_key)) begin
                n++;
                if (!f) begin
                    f = 1'b1; a = i;
                    if (!CNT) begin
                        dc = s_cyc + 2 + i;
                        return;
                    end
                end
            end
        end
        if (last_i == DEPTH - 1) dc = s_cyc + DEPTH + 1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                if (wr_en) begin
                    lq_c.push_back(cyc); lq_a.push_back(int'(wr_addr));
                    lq_v.push_back(wr_valid); lq_d.push_back(wr_data);
                end
                if (search_start && !m_busy) begin
                    has_s = 1'b1; s_cyc = cyc; s_key = search_key;
                end
            end
            cyc++;
        end
    end

    initial begin
        int dc, a, n;
        bit f;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!has_s) begin
                    dc = -2; f = 1'b0; a = 0; n = 0;
                end else begin
                    plan(cyc, dc, f, a, n);
                end
                m_busy = (dc == -1);
                check("busy", busy, dc == -1);
                check("done", done, dc == cyc);
                if (dc != -1) begin
                    check("found", found, f);
                    check("match_addr", match_addr, a);
`ifdef CAM_MATCH_COUNT_EN
                    check("match_count", match_count, n);
`endif
                end
            end
        end
    end

    task automatic wr(input int a, input int d, input bit v);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = 5'(d); wr_valid = v;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // act: 0 none, 1 write (aa,ad) at rel cycle at, 2 start pulse at at, 3 reset at at.
    task automatic search(input int key, input int act, input int at, input int aa, input int ad,
                          input int ed, input int elat, input bit ef, input int ea, input int ecnt);
        int s, lat, nd, nb, c_s;
        logic f_s;
        logic [4:0] a_s;
        s = cyc; lat = -1; nd = 0; nb = 0; f_s = 1'b0; a_s = '0; c_s = 0;
        search_key = 5'(key); search_start = 1'b1;
        if (act == 1 && at == 0) begin
            wr_en = 1'b1; wr_addr = 5'(aa); wr_data = 5'(ad); wr_valid = 1'b1;
        end
        for (int r = 0; r < 40; r++) begin
            @(posedge clk); #1;
            search_start = 1'b0; wr_en = 1'b0; search_key = ~5'(key);
            if (act != 0 && cyc - s == at) begin
                if (act == 1) begin
                    wr_en = 1'b1; wr_addr = 5'(aa); wr_data = 5'(ad); wr_valid = 1'b1;
                end else if (act == 2) begin
                    search_start = 1'b1;
                end else begin
                    rst = 1'b1;
                    #1;
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_found", found, 0);
                    check("rst_match_addr", match_addr, 0);
                    model_reset();
                    @(posedge clk); #2;
                    rst = 1'b0;
                    break;
                end
            end
            @(negedge clk);
            if (busy && nd == 0) nb++;
            if (done) begin
                nd++;
                if (lat < 0) begin
                    lat = cyc - s; f_s = found; a_s = match_addr;
`ifdef CAM_MATCH_COUNT_EN
                    c_s = int'(match_count);
`endif
                end
            end
        end
        search_start = 1'b0; wr_en = 1'b0;
        check("done_pulses", nd, ed);
        if (ed > 0) begin
            check("latency", lat, elat);
            check("busy_cycles", nb, elat - 1);
            check("lit_found", f_s, ef);
            check("lit_match_addr", a_s, ea);
            if (CNT) check("lit_match_count", c_s, ecnt);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_found", found, 0);
        check("reset_match_addr", match_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        search(3, 0, 0, 0, 0, 1, 33, 1'b0, 0, 0);
        wr(0, 5, 1); wr(1, 6, 1); wr(2, 2, 1); wr(3, 3, 1); wr(4, 1, 1); wr(5, 0, 1);
        search(3, CNT ? 0 : 2, 5, 0, 0, CNT ? 1 : 2, CNT ? 33 : 5, 1'b1, 3, 1);
        search(31, 0, 0, 0, 0, 1, 33, 1'b0, 0, 0);
        wr(4, 7, 1); wr(9, 7, 1);
        search(7, 0, 0, 0, 0, 1, CNT ? 33 : 6, 1'b1, 4, 2);
        wr(4, 0, 0);
        search(7, 2, 3, 0, 0, 1, CNT ? 33 : 11, 1'b1, 9, 1);
        search(12, 1, 3, 20, 12, 1, CNT ? 33 : 22, 1'b1, 20, 1);
        wr(20, 0, 0);
        search(12, 1, 5, 1, 12, 1, 33, 1'b0, 0, 0);
        search(17, 1, 0, 0, 17, 1, CNT ? 33 : 2, 1'b1, 0, 1);
        search(3, 1, 4, 3, 9, 1, CNT ? 33 : 5, 1'b1, 3, 1);
        search(7, 3, 10, 0, 0, 0, 0, 1'b0, 0, 0);
        search(7, 0, 0, 0, 0, 1, 33, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
